dual_port_ram: RTL and testbench
================================

# dual_port_ram

Simple dual-port synchronous RAM, 16 words × 8 bits by default. It has one write port and one independent read port, both clocked by a single clock. It is a general-purpose storage primitive for buffers and small FIFOs in the datapath. Writes and reads can target any addresses, including the same address, in the same cycle.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, address width in bits
- DEPTH, 2**ADDR_WIDTH (16), number of words

Ports:
- clk  input  1  clock; all state changes on rising edge except reset
- rst  input  1  reset, asynchronous, active-high
- din  input  DATA_WIDTH  write data
- dout  output  DATA_WIDTH  registered read data
- wr_en  input  1  write enable
- rd_en  input  1  read enable
- wr_addr  input  ADDR_WIDTH  write address
- rd_addr  input  ADDR_WIDTH  read address

Positional order for existing instantiations is clk, din, dout, wr_en, rd_en, wr_addr, rd_addr, rst. Reset is last so that positional connections of the first seven ports remain valid.

## Operation
- Storage is an array of DEPTH words of DATA_WIDTH bits. It is fully addressable, with no out-of-range addresses at default parameters.
- **Write:** on a rising clk with wr_en=1 and rst=0, mem[wr_addr] <= din. If wr_en=0, memory is unchanged.
- **Read:** on a rising clk with rd_en=1 and rst=0, dout <= mem[rd_addr]. If rd_en=0, dout holds its previous value.
- **Read-during-write, same address:** write-first. If wr_en=1, rd_en=1 and wr_addr==rd_addr in the same cycle, dout takes din, i.e. the new data.
- **Read-during-write, different addresses:** the two ports are fully independent with no interaction.
- **Reset:** rst=1 asynchronously forces dout to 0 and clears every memory word to 0. While rst is high, writes and reads are ignored.
- **Release of reset:** normal operation starts at the first rising clk edge with rst=0.
- Unwritten locations read as 0 after reset.
- No arithmetic, no address wrap logic, and no status flags.

## Timing
- Write latency is 1 cycle. Data written at edge N is readable at edge N+1 or later through a normal read. It is readable at edge N through the same-address bypass.
- Read latency is 1 cycle. rd_addr is sampled at edge N, and dout is valid after edge N and stable until the next enabled read edge.
- dout reset value is 0.
- Reset mid-operation takes effect immediately, without waiting for clk. Any write coinciding with assertion is discarded, and all contents read as 0 afterwards.
- Inputs must be stable around the rising clk edge. The bench drives them on the falling edge.
- Full throughput: one write and one read every cycle, indefinitely.

## Test plan
- **Reset:** pulse rst high between clock edges -> dout=0 immediately. Then read addresses 0..15 with rd_en=1 -> dout=0 for each.
- **Simultaneous write/read sweep:** each cycle i=0..15 drive wr_en=1, wr_addr=i, din=i, rd_en=1, rd_addr=i -> after edge i, dout=i (write-first bypass). Afterwards, read addresses 0..15 again -> dout=0x00..0x0F.
- **Enable gating:** write 0xA5 to address 3, then drive wr_en=0 with din=0xFF to address 3 -> a subsequent read of 3 gives 0xA5. Then hold rd_en=0 while changing rd_addr -> dout stays at its last value.
- **Independent ports:** in the same cycle, write 0x3C to address 7 and read address 2, which holds 0x02 -> dout=0x02. Next cycle read address 7 -> dout=0x3C.
- **Reset mid-operation:** fill addresses 0..15 with 0x10+i, then assert rst during a write burst -> dout=0 at once. After release, reading any address gives 0.

Source files
------------

// File: rtl/dual_port_ram.sv
// dual_port_ram: simple dual-port synchronous RAM.
// One write port and one independent read port share a single clock.
// The read data is registered. When both ports hit the same address in
// the same cycle, the read returns the word being written (write-first).
// An asynchronous active-high reset clears dout and every storage word.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rst
);

    // Storage words. They are flops so that reset can clear them asynchronously.
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Read data register that drives dout.
    logic [DATA_WIDTH-1:0] dout_r;

    // Data selected for the next enabled read (bypass or stored word).
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Address range qualifiers. They only matter when DEPTH is not a power of two.
    logic                  wr_in_range_s;
    logic                  rd_in_range_s;

    // Same-address collision between the write and read ports.
    logic                  same_addr_s;

    // Qualify both addresses against DEPTH and detect a same-address collision.
    always_comb begin
        wr_in_range_s = 1'b0;
        rd_in_range_s = 1'b0;
        same_addr_s   = 1'b0;
        if (32'(wr_addr) < 32'(DEPTH)) begin
            wr_in_range_s = 1'b1;
        end else begin
            wr_in_range_s = 1'b0;
        end
        if (32'(rd_addr) < 32'(DEPTH)) begin
            rd_in_range_s = 1'b1;
        end else begin
            rd_in_range_s = 1'b0;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            same_addr_s = 1'b1;
        end else begin
            same_addr_s = 1'b0;
        end
    end

    // Select the read data. A colliding write wins so that dout sees the new word.
    always_comb begin
        rd_data_s = '0;
        if (same_addr_s) begin
            rd_data_s = din;
        end else if (rd_in_range_s) begin
            rd_data_s = mem_r[rd_addr];
        end else begin
            rd_data_s = '0;
        end
    end

    // Write port. Reset clears every word and discards any coinciding write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en && wr_in_range_s) begin
            mem_r[wr_addr] <= din;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Read port. The register loads only on an enabled read and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r <= '0;
        end else if (rd_en) begin
            dout_r <= rd_data_s;
        end else begin
            dout_r <= dout_r;
        end
    end

    assign dout = dout_r;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram. Inputs change on the falling edge.
// Expected dout values are pushed to a scoreboard queue when a cycle is
// driven, and popped and compared on the following falling edge.
module tb_dual_port_ram;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [7:0] dout;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] wr_addr;
    logic [3:0] rd_addr;

    int         checks;
    int         failures;

    logic [7:0] model [16];
    logic [7:0] last_exp;
    logic [7:0] sb_q [$];
    logic [7:0] exp_v;

    dual_port_ram #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .DEPTH     (16)
    ) dut (
        .clk    (clk),
        .din    (din),
        .dout   (dout),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr),
        .rst    (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clear the reference model after a reset.
    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        last_exp = 8'h00;
        sb_q.delete();
    endtask

    // Drive one cycle starting at a falling edge and push the expected dout.
    task automatic step(input logic we, input logic [3:0] wa, input logic [7:0] d,
                        input logic re, input logic [3:0] ra);
        wr_en   = we;
        wr_addr = wa;
        din     = d;
        rd_en   = re;
        rd_addr = ra;
        if (re) begin
            if (we && (wa == ra)) last_exp = d;
            else                  last_exp = model[ra];
        end
        sb_q.push_back(last_exp);
        if (we) model[wa] = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        // Pulse reset between edges; dout must clear at once.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_immediate dout=%h expected=%h", dout, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'h0, 8'h00, 1'b1, 4'(i));
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL reset_read scoreboard empty at addr %0d", i);
            end else begin
                exp_v = sb_q.pop_front();
                if (dout !== exp_v) begin
                    failures++;
                    $display("FAIL reset_read addr=%0d dout=%h expected=%h", i, dout, exp_v);
                end
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 8'(i), 1'b1, 4'(i));
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sweep_bypass scoreboard empty at %0d", i);
            end else begin
                exp_v = sb_q.pop_front();
                if (dout !== exp_v) begin
                    failures++;
                    $display("FAIL sweep_bypass addr=%0d dout=%h expected=%h", i, dout, exp_v);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'h0, 8'h00, 1'b1, 4'(i));
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sweep_readback scoreboard empty at %0d", i);
            end else begin
                exp_v = sb_q.pop_front();
                if (dout !== exp_v) begin
                    failures++;
                    $display("FAIL sweep_readback addr=%0d dout=%h expected=%h", i, dout, exp_v);
                end
            end
        end
    endtask

    task automatic test_enable_gating();
        step(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
        step(1'b0, 4'd3, 8'hFF, 1'b0, 4'd0);
        sb_q.delete();
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        checks++;
        exp_v = sb_q.pop_front();
        if (dout !== exp_v) begin
            failures++;
            $display("FAIL wr_gate dout=%h expected=%h", dout, exp_v);
        end
        // rd_en low: dout must hold the last read while rd_addr moves.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd0, 8'h00, 1'b0, 4'(i * 5));
            checks++;
            exp_v = sb_q.pop_front();
            if (dout !== exp_v) begin
                failures++;
                $display("FAIL rd_hold step=%0d dout=%h expected=%h", i, dout, exp_v);
            end
        end
    endtask

    task automatic test_independent();
        step(1'b1, 4'd7, 8'h3C, 1'b1, 4'd2);
        checks++;
        exp_v = sb_q.pop_front();
        if (dout !== exp_v) begin
            failures++;
            $display("FAIL indep_read2 dout=%h expected=%h", dout, exp_v);
        end
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
        checks++;
        exp_v = sb_q.pop_front();
        if (dout !== exp_v) begin
            failures++;
            $display("FAIL indep_read7 dout=%h expected=%h", dout, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic       we;
        logic       re;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [7:0] d;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 3) != 0);
            wa = 4'($urandom_range(0, 15));
            ra = (i % 4 == 0) ? wa : 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            step(we, wa, d, re, ra);
            checks++;
            exp_v = sb_q.pop_front();
            if (dout !== exp_v) begin
                failures++;
                $display("FAIL b2b cycle=%0d dout=%h expected=%h", i, dout, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 4'd0);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
        sb_q.delete();
        checks++;
        if (dout !== 8'h15) begin
            failures++;
            $display("FAIL pre_reset_read dout=%h expected=%h", dout, 8'h15);
        end
        // Write burst with reset asserted between edges; the write is discarded.
        wr_en   = 1'b1;
        wr_addr = 4'd9;
        din     = 8'hEE;
        rd_en   = 1'b1;
        rd_addr = 4'd9;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_immediate dout=%h expected=%h", dout, 8'h00);
        end
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 8'h00, 1'b1, 4'(15 - i));
            checks++;
            exp_v = sb_q.pop_front();
            if (dout !== exp_v) begin
                failures++;
                $display("FAIL post_reset_read addr=%0d dout=%h expected=%h", 15 - i, dout, exp_v);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        din      = 8'h00;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_addr  = 4'h0;
        rd_addr  = 4'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_sweep();
        test_enable_gating();
        test_independent();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
